// File: rtl/inv_key_schedule_if.sv
// Handshake bundle between the key register, the decryption key scheduler and
// the inverse-cipher datapath that consumes the round keys.
interface inv_key_schedule_if;
   localparam int unsigned KEY_W = 128;
   localparam int unsigned RND_W = 4;

   logic             start;
   logic             key_is_last;
   logic [KEY_W-1:0] key_in;
   logic [KEY_W-1:0] round_key;
   logic [RND_W-1:0] key_round;
   logic             key_valid;
   logic             key_ready;
   logic             busy;
   logic             done;

   modport slave (
      input  start, key_is_last, key_in, key_ready,
      output round_key, key_round, key_valid, busy, done
   );

   modport master (
      output start, key_is_last, key_in, key_ready,
      input  round_key, key_round, key_valid, busy, done
   );
endinterface

// File: rtl/inv_key_schedule.sv
// AES-128 decryption round-key generator: emits round keys 10..0, one per
// handshake, optionally running the forward expansion to round 10 first.
module inv_key_schedule #(
   parameter int unsigned NR = 10
) (
   input logic               clk,
   input logic               reset_n,
   inv_key_schedule_if.slave kif
);
   localparam int unsigned KEY_W  = 128;
   localparam int unsigned RND_W  = 4;
   localparam int unsigned WORD_W = 32;
   localparam logic [RND_W-1:0] LAST_RND = RND_W'(NR);

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   typedef enum logic [1:0] {S_IDLE, S_FWD, S_EMIT} state_e;

   function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [WORD_W-1:0] get_rcon(input logic [RND_W-1:0] idx);
      logic [7:0] b;
      case (idx)
         4'd1:    b = 8'h01;
         4'd2:    b = 8'h02;
         4'd3:    b = 8'h04;
         4'd4:    b = 8'h08;
         4'd5:    b = 8'h10;
         4'd6:    b = 8'h20;
         4'd7:    b = 8'h40;
         4'd8:    b = 8'h80;
         4'd9:    b = 8'h1b;
         4'd10:   b = 8'h36;
         default: b = 8'h00;
      endcase
      return {b, 24'h000000};
   endfunction

   state_e           state_q, state_d;
   logic [KEY_W-1:0] round_key_q, round_key_d;
   logic [RND_W-1:0] key_round_q, key_round_d;
   logic [RND_W-1:0] cnt_q, cnt_d;
   logic             key_valid_q, key_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WORD_W-1:0] w0, w1, w2, w3;
   logic [WORD_W-1:0] inv_w1, inv_w2, inv_w3;
   logic [WORD_W-1:0] sub_in, mix_word;
   logic [RND_W-1:0]  rcon_idx;
   logic [KEY_W-1:0]  fwd_key, inv_key;

   // One shared SubWord serves both directions; FWD and EMIT never overlap.
   always_comb begin
      {w0, w1, w2, w3} = round_key_q;
      inv_w3   = w3 ^ w2;
      inv_w2   = w2 ^ w1;
      inv_w1   = w1 ^ w0;
      sub_in   = (state_q == S_FWD) ? rot_word(w3) : rot_word(inv_w3);
      rcon_idx = (state_q == S_FWD) ? cnt_q : key_round_q;
      mix_word = sub_word(sub_in) ^ get_rcon(rcon_idx);
      fwd_key  = {w0 ^ mix_word,
                  w1 ^ w0 ^ mix_word,
                  w2 ^ w1 ^ w0 ^ mix_word,
                  w3 ^ w2 ^ w1 ^ w0 ^ mix_word};
      inv_key  = {w0 ^ mix_word, inv_w1, inv_w2, inv_w3};
   end

   always_comb begin
      state_d     = state_q;
      round_key_d = round_key_q;
      key_round_d = key_round_q;
      cnt_d       = cnt_q;
      key_valid_d = key_valid_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (kif.start) begin
               round_key_d = kif.key_in;
               busy_d      = 1'b1;
               if (kif.key_is_last) begin
                  state_d     = S_EMIT;
                  key_round_d = LAST_RND;
                  key_valid_d = 1'b1;
                  cnt_d       = RND_W'(0);
               end else begin
                  state_d     = S_FWD;
                  key_round_d = RND_W'(0);
                  key_valid_d = 1'b0;
                  cnt_d       = RND_W'(1);
               end
            end
         end
         S_FWD: begin
            round_key_d = fwd_key;
            if (cnt_q == LAST_RND) begin
               state_d     = S_EMIT;
               key_round_d = LAST_RND;
               key_valid_d = 1'b1;
               cnt_d       = RND_W'(0);
            end else begin
               cnt_d = cnt_q + RND_W'(1);
            end
         end
         S_EMIT: begin
            if (kif.key_ready) begin
               if (key_round_q != RND_W'(0)) begin
                  round_key_d = inv_key;
                  key_round_d = key_round_q - RND_W'(1);
               end else begin
                  state_d     = S_IDLE;
                  key_valid_d = 1'b0;
                  busy_d      = 1'b0;
                  done_d      = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         round_key_q <= '0;
         key_round_q <= '0;
         cnt_q       <= '0;
         key_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         round_key_q <= round_key_d;
         key_round_q <= key_round_d;
         cnt_q       <= cnt_d;
         key_valid_q <= key_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign kif.round_key = round_key_q;
   assign kif.key_round = key_round_q;
   assign kif.key_valid = key_valid_q;
   assign kif.busy      = busy_q;
   assign kif.done      = done_q;
endmodule

// File: tb/tb_inv_key_schedule.sv
// Scoreboard bench for inv_key_schedule: FIPS-197 and all-zero key sequences
// under full-rate, backpressured, ignored-start, abort and back-to-back traffic.
module tb_inv_key_schedule;
   localparam logic [127:0] FIPS_RK [0:10] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
   };
   localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   typedef struct { logic [3:0] rnd; logic [127:0] key; bit chk; } exp_t;
   typedef struct { logic [3:0] rnd; logic [127:0] key; } obs_t;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   inv_key_schedule_if bus ();
   inv_key_schedule #(.NR(10)) dut (.clk(clk), .reset_n(reset_n), .kif(bus));

   exp_t exp_q[$];
   obs_t obs_q[$];
   int pass_cnt = 0;
   int total_cnt = 0;
   int first_valid, last_xfer_c, done_c, stab_err, busy_err;

   function automatic void push_fips();
      for (int r = 10; r >= 0; r--) exp_q.push_back('{rnd: 4'(r), key: FIPS_RK[r], chk: 1'b1});
   endfunction

   function automatic void push_zero();
      for (int r = 10; r >= 0; r--)
         exp_q.push_back('{rnd: 4'(r), key: (r == 10) ? ZERO_R10 : 128'h0, chk: (r == 10 || r == 0)});
   endfunction

   task automatic kick(input logic [127:0] key, input logic last);
      @(negedge clk);
      bus.start       = 1'b1;
      bus.key_is_last = last;
      bus.key_in      = key;
   endtask

   // Drives key_ready and records transfers until done (or abort_rnd transfer / budget).
   task automatic run_seq(input int budget, input int ready_pct, input bit pulses,
                          input bit chain, input logic [127:0] chain_key, input int abort_rnd);
      logic          hold;
      logic [127:0]  prev_key;
      logic [3:0]    prev_rnd;
      bit            rdy;
      obs_q.delete();
      first_valid = -1; last_xfer_c = -1; done_c = -1; stab_err = 0; busy_err = 0;
      hold = 1'b0; prev_key = '0; prev_rnd = '0;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (pulses && (c == 5 || c == 14)) begin
            bus.start       = 1'b1;
            bus.key_is_last = 1'($urandom_range(1));
            bus.key_in      = {$urandom, $urandom, $urandom, $urandom};
         end
         if (bus.done === 1'b1) begin
            done_c = c;
            if (chain) begin
               bus.start       = 1'b1;
               bus.key_is_last = 1'b0;
               bus.key_in      = chain_key;
            end
            break;
         end
         if (bus.busy !== 1'b1) busy_err++;
         if (bus.key_valid === 1'b1) begin
            if (first_valid < 0) first_valid = c;
            if (hold && (bus.round_key !== prev_key || bus.key_round !== prev_rnd)) stab_err++;
            rdy = (int'($urandom_range(99)) < ready_pct);
            bus.key_ready = rdy;
            if (rdy) begin
               obs_q.push_back('{rnd: bus.key_round, key: bus.round_key});
               last_xfer_c = c;
               hold = 1'b0;
               if (int'(bus.key_round) == abort_rnd) break;
            end else begin
               hold = 1'b1; prev_key = bus.round_key; prev_rnd = bus.key_round;
            end
         end else begin
            bus.key_ready = 1'($urandom_range(1));
            hold = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus.start = 1'b0; bus.key_is_last = 1'b0; bus.key_in = '0; bus.key_ready = 1'b0;
      repeat (2) @(negedge clk);
      total_cnt += 5;
      if (bus.round_key !== 128'h0) $display("FAIL reset_round_key got %h want 0", bus.round_key); else pass_cnt++;
      if (bus.key_round !== 4'h0) $display("FAIL reset_key_round got %0d want 0", bus.key_round); else pass_cnt++;
      if (bus.key_valid !== 1'b0) $display("FAIL reset_key_valid got %b want 0", bus.key_valid); else pass_cnt++;
      if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else pass_cnt++;
      if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else pass_cnt++;
      reset_n = 1'b1;
   endtask

   task automatic test_fips();
      exp_t e;
      push_fips();
      kick(FIPS_RK[0], 1'b0);
      run_seq(200, 100, 1'b0, 1'b0, '0, -1);
      total_cnt += 4;
      if (done_c < 0) $display("FAIL fips_done_seen got timeout want done"); else pass_cnt++;
      if (first_valid != 11) $display("FAIL fips_latency got %0d want 11", first_valid); else pass_cnt++;
      if (done_c != last_xfer_c + 1) $display("FAIL fips_done_timing got %0d want %0d", done_c, last_xfer_c + 1); else pass_cnt++;
      if (busy_err != 0 || bus.busy !== 1'b0) $display("FAIL fips_busy got err=%0d busy=%b want 0/0", busy_err, bus.busy); else pass_cnt++;
      for (int i = 0; i < 11; i++) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (i >= obs_q.size()) $display("FAIL fips_seq[%0d] got missing want r%0d %h", i, e.rnd, e.key);
         else if (obs_q[i].rnd !== e.rnd || obs_q[i].key !== e.key)
            $display("FAIL fips_seq[%0d] got r%0d %h want r%0d %h", i, obs_q[i].rnd, obs_q[i].key, e.rnd, e.key);
         else pass_cnt++;
      end
      @(negedge clk);
      total_cnt += 2;
      if (bus.done !== 1'b0 || bus.key_valid !== 1'b0) $display("FAIL fips_after_done got done=%b valid=%b want 0/0", bus.done, bus.key_valid); else pass_cnt++;
      if (bus.round_key !== FIPS_RK[0] || bus.key_round !== 4'h0)
         $display("FAIL fips_retain got r%0d %h want r0 %h", bus.key_round, bus.round_key, FIPS_RK[0]); else pass_cnt++;
   endtask

   task automatic test_direct();
      exp_t e;
      push_fips();
      kick(FIPS_RK[10], 1'b1);
      run_seq(200, 100, 1'b0, 1'b0, '0, -1);
      total_cnt += 2;
      if (first_valid != 1) $display("FAIL direct_latency got %0d want 1", first_valid); else pass_cnt++;
      if (done_c != last_xfer_c + 1) $display("FAIL direct_done_timing got %0d want %0d", done_c, last_xfer_c + 1); else pass_cnt++;
      for (int i = 0; i < 11; i++) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (i >= obs_q.size()) $display("FAIL direct_seq[%0d] got missing want r%0d", i, e.rnd);
         else if (obs_q[i].rnd !== e.rnd || obs_q[i].key !== e.key)
            $display("FAIL direct_seq[%0d] got r%0d %h want r%0d %h", i, obs_q[i].rnd, obs_q[i].key, e.rnd, e.key);
         else pass_cnt++;
      end
   endtask

   task automatic test_backpressure();
      exp_t e;
      push_fips();
      kick(FIPS_RK[0], 1'b0);
      run_seq(600, 40, 1'b0, 1'b0, '0, -1);
      total_cnt += 4;
      if (done_c < 0) $display("FAIL bp_done_seen got timeout want done"); else pass_cnt++;
      if (first_valid != 11) $display("FAIL bp_latency got %0d want 11", first_valid); else pass_cnt++;
      if (stab_err != 0) $display("FAIL bp_stable got %0d changes want 0", stab_err); else pass_cnt++;
      if (obs_q.size() != 11) $display("FAIL bp_count got %0d want 11", obs_q.size()); else pass_cnt++;
      for (int i = 0; i < 11; i++) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (i >= obs_q.size()) $display("FAIL bp_seq[%0d] got missing want r%0d", i, e.rnd);
         else if (obs_q[i].rnd !== e.rnd || obs_q[i].key !== e.key)
            $display("FAIL bp_seq[%0d] got r%0d %h want r%0d %h", i, obs_q[i].rnd, obs_q[i].key, e.rnd, e.key);
         else pass_cnt++;
      end
   endtask

   task automatic test_ignored_start();
      exp_t e;
      push_fips();
      kick(FIPS_RK[0], 1'b0);
      run_seq(200, 100, 1'b1, 1'b0, '0, -1);
      total_cnt += 3;
      if (first_valid != 11) $display("FAIL ign_latency got %0d want 11", first_valid); else pass_cnt++;
      if (done_c != 22) $display("FAIL ign_done_cycle got %0d want 22", done_c); else pass_cnt++;
      if (busy_err != 0) $display("FAIL ign_busy got %0d drops want 0", busy_err); else pass_cnt++;
      for (int i = 0; i < 11; i++) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (i >= obs_q.size()) $display("FAIL ign_seq[%0d] got missing want r%0d", i, e.rnd);
         else if (obs_q[i].rnd !== e.rnd || obs_q[i].key !== e.key)
            $display("FAIL ign_seq[%0d] got r%0d %h want r%0d %h", i, obs_q[i].rnd, obs_q[i].key, e.rnd, e.key);
         else pass_cnt++;
      end
   endtask

   task automatic test_abort();
      exp_t e;
      int   done_during;
      push_fips();
      kick(FIPS_RK[0], 1'b0);
      run_seq(200, 100, 1'b0, 1'b0, '0, 6);
      for (int i = 0; i < 5; i++) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (i >= obs_q.size()) $display("FAIL abort_pre[%0d] got missing want r%0d", i, e.rnd);
         else if (obs_q[i].rnd !== e.rnd || obs_q[i].key !== e.key)
            $display("FAIL abort_pre[%0d] got r%0d %h want r%0d %h", i, obs_q[i].rnd, obs_q[i].key, e.rnd, e.key);
         else pass_cnt++;
      end
      exp_q.delete();
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      total_cnt++;
      if (bus.round_key !== 128'h0 || bus.key_round !== 4'h0 || bus.key_valid !== 1'b0 ||
          bus.busy !== 1'b0 || bus.done !== 1'b0)
         $display("FAIL abort_async got key=%h r=%0d v=%b busy=%b done=%b want all 0",
                  bus.round_key, bus.key_round, bus.key_valid, bus.busy, bus.done);
      else pass_cnt++;
      done_during = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.done !== 1'b0) done_during++;
      end
      reset_n = 1'b1;
      @(negedge clk);
      if (bus.done !== 1'b0) done_during++;
      total_cnt++;
      if (done_during != 0) $display("FAIL abort_no_done got %0d pulses want 0", done_during); else pass_cnt++;
      push_fips();
      kick(FIPS_RK[0], 1'b0);
      run_seq(200, 100, 1'b0, 1'b0, '0, -1);
      total_cnt++;
      if (first_valid != 11) $display("FAIL abort_restart_latency got %0d want 11", first_valid); else pass_cnt++;
      for (int i = 0; i < 11; i++) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (i >= obs_q.size()) $display("FAIL abort_restart[%0d] got missing want r%0d", i, e.rnd);
         else if (obs_q[i].rnd !== e.rnd || obs_q[i].key !== e.key)
            $display("FAIL abort_restart[%0d] got r%0d %h want r%0d %h", i, obs_q[i].rnd, obs_q[i].key, e.rnd, e.key);
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      push_fips();
      kick(FIPS_RK[10], 1'b1);
      run_seq(200, 100, 1'b0, 1'b1, 128'h0, -1);
      for (int i = 0; i < 11; i++) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (i >= obs_q.size()) $display("FAIL b2b_first[%0d] got missing want r%0d", i, e.rnd);
         else if (obs_q[i].rnd !== e.rnd || obs_q[i].key !== e.key)
            $display("FAIL b2b_first[%0d] got r%0d %h want r%0d %h", i, obs_q[i].rnd, obs_q[i].key, e.rnd, e.key);
         else pass_cnt++;
      end
      push_zero();
      run_seq(200, 100, 1'b0, 1'b0, '0, -1);
      total_cnt += 2;
      if (first_valid != 11) $display("FAIL b2b_latency got %0d want 11", first_valid); else pass_cnt++;
      if (done_c < 0) $display("FAIL b2b_done_seen got timeout want done"); else pass_cnt++;
      for (int i = 0; i < 11; i++) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (i >= obs_q.size()) $display("FAIL b2b_zero[%0d] got missing want r%0d", i, e.rnd);
         else if (obs_q[i].rnd !== e.rnd || (e.chk && obs_q[i].key !== e.key))
            $display("FAIL b2b_zero[%0d] got r%0d %h want r%0d %h", i, obs_q[i].rnd, obs_q[i].key, e.rnd, e.key);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_fips();
      test_direct();
      test_backpressure();
      test_ignored_start();
      test_abort();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got no finish want finish by 500us");
      $fatal(1);
   end
endmodule

// File: doc/inv_key_schedule.md
Name: inv_key_schedule

Overview:
- Generates the AES-128 decryption round-key sequence: round keys 10, 9, …, 0, one per handshake, in reverse of the forward key expansion.
- Sits between the key register and the inverse-cipher datapath (InvAddRoundKey source).
- Accepts either the cipher key (internally runs forward expansion to round 10 first) or the round-10 key directly.
- Reuses the codebase sBox, rotWord and getRcon leaf modules.

Parameters:
NR, 10, number of AES rounds; fixed at 10 (AES-128 only), other values unsupported.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a sequence; ignored while busy=1
key_is_last  input  1  sampled with start: 1 = key_in is round-10 key, 0 = key_in is cipher key
key_in  input  128  key; w0 at [127:96], w3 at [31:0]
round_key  output  128  current round key (same word ordering)
key_round  output  4  round index of round_key (10 down to 0)
key_valid  output  1  round_key/key_round valid
key_ready  input  1  consumer accepts round_key this cycle when key_valid=1
busy  output  1  sequence in progress (FWD or EMIT)
done  output  1  one-cycle pulse after round 0 is accepted

Behaviour:
- Reset (async, reset_n=0): state=IDLE; round_key=0, key_round=0, key_valid=0, busy=0, done=0; internal round counter=0.
- States IDLE, FWD, EMIT.
- IDLE: start=1 loads key_in into the key register and sets busy=1 next cycle.
  - key_is_last=1: go to EMIT with key_round=10, key_valid=1 on the next cycle (latency 1).
  - key_is_last=0: go to FWD with counter=1.
- FWD: one forward expansion step per cycle, using Rcon(counter) and the forward word recurrence (w0'=w0^SubWord(RotWord(w3))^Rcon, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2').
  - After the step with counter=10, go to EMIT with key_round=10, key_valid=1.
  - key_valid first asserts 11 cycles after the start cycle.
  - key_valid=0 throughout FWD.
- EMIT: key_valid=1, and round_key/key_round are held stable while key_ready=0.
  - On transfer (key_valid & key_ready) with key_round=r>0: next cycle shows the key for round r-1, computed by the inverse step using Rcon(r):
    - w3'=w3^w2
    - w2'=w2^w1
    - w1'=w1^w0
    - w0'=w0^SubWord(RotWord(w3'))^Rcon(r)
  - key_valid stays 1, so one key per cycle is delivered when key_ready is held high (11 transfers in 11 cycles).
  - On transfer with key_round=0: next cycle key_valid=0, busy=0, done=1 for one cycle, state=IDLE.
  - round_key retains the round-0 value; key_round=0.
- start is ignored in FWD and EMIT; there is no abort. Abort is done by asserting reset_n=0.
- Reset mid-FWD or mid-EMIT returns all outputs to reset values immediately (asynchronously); no partial done.
- start in the same cycle as done=1 (state already IDLE) is accepted.
- Rcon table: 01,02,04,08,10,20,40,80,1B,36 in bits [31:24], indexed 1..10.
- All arithmetic is bytewise XOR / GF(2^8) via sBox; no carries.
- Single-cycle combinational step, either forward or inverse, selected by state. One shared SubWord (4 sBox) instance is permitted, since FWD and EMIT are exclusive.
- key_in is sampled only on an accepted start; later changes to it have no effect.

Test Plan:
- FIPS-197 key: start, key_is_last=0, key_in=2b7e151628aed2a6abf7158809cf4f3c, key_ready=1.
  - key_valid rises 11 cycles after start with key_round=10, round_key=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Next cycle: round 9 = ac7766f319fadc2128d12941575c006e.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 0 = 2b7e1516…cf4f3c.
  - done pulses one cycle after the round-0 transfer.
- Direct mode: key_is_last=1, key_in=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - key_valid asserts in the cycle after start.
  - Same 11-key sequence as the first scenario, ending in 2b7e151628aed2a6abf7158809cf4f3c.
- Backpressure: randomize key_ready (≈40% high).
  - round_key/key_round stay stable while key_valid=1 and key_ready=0.
  - The sequence matches the first scenario exactly, with no skipped or duplicated rounds.
- start pulses during FWD and during EMIT are ignored.
  - Sequence and timing are unchanged; busy=1 throughout.
- Assert reset_n=0 after the round-6 transfer:
  - All outputs are 0 immediately, state=IDLE, no done.
  - A fresh start afterwards produces the full correct sequence.
- Back-to-back: start asserted in the cycle done=1 with an all-zero cipher key.
  - Round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
  - Round 0 = 0.
